// File: rtl/mem_access_unit_if.sv
// Load/store port bundle between the EX/MEM stage, the data memory and writeback.
// The slave modport is the access unit itself. The master modport is the side that drives requests and memory responses.
interface mem_access_unit_if;
    logic        reqValid;
    logic        reqWrite;
    logic        reqByte;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic [4:0]  rdIn;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [3:0]  memBe;
    logic        memAck;
    logic [31:0] memRData;
    logic        loadValid;
    logic [31:0] loadWord;
    logic [7:0]  loadByte;
    logic        loadIsByte;
    logic        ExtByte;
    logic [4:0]  rdOut;
    logic        accessErr;

    modport slave (
        input  reqValid, reqWrite, reqByte, reqSigned, reqAddr, reqWData, rdIn,
        input  memAck, memRData,
        output stall, memReq, memWe, memAddr, memWData, memBe,
        output loadValid, loadWord, loadByte, loadIsByte, ExtByte, rdOut, accessErr
    );

    modport master (
        output reqValid, reqWrite, reqByte, reqSigned, reqAddr, reqWData, rdIn,
        output memAck, memRData,
        input  stall, memReq, memWe, memAddr, memWData, memBe,
        input  loadValid, loadWord, loadByte, loadIsByte, ExtByte, rdOut, accessErr
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store sequencer. A load result appears two cycles after acceptance when memory acks at once.
// The stall output holds the pipeline from acceptance until memAck arrives. It also drops in the cycle a timeout fires.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      r_state;
    logic        r_write;
    logic        r_byte;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic [4:0]  r_rd;
    logic [7:0]  r_cnt;

    logic        w_can_accept;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_reject;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;

    assign w_can_accept = (r_state == IDLE) || (r_state == RESP);
    assign w_misaligned = !bus.reqByte && (bus.reqAddr[1:0] != 2'b00);
    assign w_accept     = w_can_accept && bus.reqValid && !w_misaligned;
    assign w_reject     = w_can_accept && bus.reqValid && w_misaligned;
    assign w_timeout    = (r_state == BUSY) && !bus.memAck && (r_cnt == LAST_WAIT);

    assign w_be      = (bus.reqWrite && bus.reqByte) ? (4'b0001 << bus.reqAddr[1:0]) : 4'hF;
    assign w_wdata   = bus.reqByte ? {4{bus.reqWData[7:0]}} : bus.reqWData;
    assign w_shifted = bus.memRData >> {r_lane, 3'b000};

    // The timeout cycle releases the pipeline, the same way an ack does.
    assign bus.stall = !reset &&
                       (w_accept || ((r_state == BUSY) && !bus.memAck && !w_timeout));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_write        <= 1'b0;
            r_byte         <= 1'b0;
            r_signed       <= 1'b0;
            r_lane         <= 2'b00;
            r_rd           <= 5'd0;
            r_cnt          <= 8'd0;
            bus.memReq     <= 1'b0;
            bus.memWe      <= 1'b0;
            bus.memAddr    <= 32'd0;
            bus.memWData   <= 32'd0;
            bus.memBe      <= 4'd0;
            bus.loadValid  <= 1'b0;
            bus.loadWord   <= 32'd0;
            bus.loadByte   <= 8'd0;
            bus.loadIsByte <= 1'b0;
            bus.ExtByte    <= 1'b0;
            bus.rdOut      <= 5'd0;
            bus.accessErr  <= 1'b0;
        end else begin
            bus.loadValid <= 1'b0;
            bus.accessErr <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_write      <= bus.reqWrite;
                        r_byte       <= bus.reqByte;
                        r_signed     <= bus.reqSigned;
                        r_lane       <= bus.reqAddr[1:0];
                        r_rd         <= bus.rdIn;
                        r_cnt        <= 8'd0;
                        bus.memReq   <= 1'b1;
                        bus.memWe    <= bus.reqWrite;
                        bus.memAddr  <= {bus.reqAddr[31:2], 2'b00};
                        bus.memWData <= w_wdata;
                        bus.memBe    <= w_be;
                        r_state      <= BUSY;
                    end else begin
                        bus.accessErr <= w_reject;
                        r_state       <= IDLE;
                    end
                end
                BUSY: begin
                    if (bus.memAck) begin
                        bus.memReq     <= 1'b0;
                        r_cnt          <= 8'd0;
                        bus.loadValid  <= !r_write;
                        bus.loadWord   <= bus.memRData;
                        bus.loadByte   <= w_shifted[7:0];
                        bus.loadIsByte <= r_byte;
                        bus.ExtByte    <= r_signed;
                        bus.rdOut      <= r_rd;
                        r_state        <= RESP;
                    end else if (w_timeout) begin
                        bus.memReq    <= 1'b0;
                        r_cnt         <= 8'd0;
                        bus.accessErr <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of complete load/store transactions plus
// hand-written sequences for misalignment, timeout, back-to-back requests and reset mid-access.
module tb_mem_access_unit;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mem_access_unit_if bus();

    mem_access_unit #(.MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        byt;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [7:0]  e_lbyte;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int stalls;
        stalls = 0;
        bus.reqValid  = 1'b1;
        bus.reqWrite  = v.wr;
        bus.reqByte   = v.byt;
        bus.reqSigned = v.sgn;
        bus.reqAddr   = v.addr;
        bus.reqWData  = v.wdata;
        bus.rdIn      = v.rd;
        #1;
        chk("accept_stall", 32'(bus.stall), 32'd1);
        if (bus.stall === 1'b1) stalls++;
        tick();
        bus.reqValid = 1'b0;
        chk("busy_memReq", 32'(bus.memReq), 32'd1);
        chk("busy_memWe", 32'(bus.memWe), 32'(v.wr));
        chk("busy_memAddr", bus.memAddr, v.e_addr);
        chk("busy_memBe", 32'(bus.memBe), 32'(v.e_be));
        if (v.wr) chk("busy_memWData", bus.memWData, v.e_wdata);
        for (int k = 0; k < v.delay; k++) begin
            bus.memAck = 1'b0;
            #1;
            if (bus.stall === 1'b1) stalls++;
            chk("wait_memReq", 32'(bus.memReq), 32'd1);
            tick();
        end
        bus.memAck   = 1'b1;
        bus.memRData = v.rdata;
        #1;
        chk("ack_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.memAck = 1'b0;
        chk("stall_cycles", 32'(stalls), 32'(v.delay + 1));
        chk("resp_memReq", 32'(bus.memReq), 32'd0);
        chk("resp_loadValid", 32'(bus.loadValid), 32'(!v.wr));
        chk("resp_accessErr", 32'(bus.accessErr), 32'd0);
        if (!v.wr) begin
            chk("resp_loadWord", bus.loadWord, v.rdata);
            chk("resp_loadByte", 32'(bus.loadByte), 32'(v.e_lbyte));
            chk("resp_loadIsByte", 32'(bus.loadIsByte), 32'(v.byt));
            chk("resp_ExtByte", 32'(bus.ExtByte), 32'(v.sgn));
            chk("resp_rdOut", 32'(bus.rdOut), 32'(v.rd));
        end
        tick();
        chk("post_loadValid", 32'(bus.loadValid), 32'd0);
    endtask

    initial begin
        int busy;
        n_tests = 0;
        n_fail  = 0;

        //        wr    byt   sgn   addr          wdata          rd     rdata          dly  e_addr        e_be     e_wdata        e_lbyte
        vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'h0,         5'd5,  32'h80FF_1234, 2,   32'h0000_0100, 4'hF,    32'h0,         8'h80};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0202, 32'h0000_00A5, 5'd6,  32'h0,         0,   32'h0000_0200, 4'b0100, 32'hA5A5_A5A5, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         5'd31, 32'hDEAD_BEEF, 0,   32'h0000_0040, 4'hF,    32'h0,         8'hEF};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_1004, 32'h1234_5678, 5'd2,  32'h0,         1,   32'h0000_1004, 4'hF,    32'h1234_5678, 8'h00};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h0,         5'd7,  32'h1122_3344, 1,   32'h0000_0000, 4'hF,    32'h0,         8'h33};

        reset         = 1'b1;
        bus.reqValid  = 1'b1;
        bus.reqWrite  = 1'b0;
        bus.reqByte   = 1'b0;
        bus.reqSigned = 1'b0;
        bus.reqAddr   = 32'h0000_0100;
        bus.reqWData  = 32'h0;
        bus.rdIn      = 5'd0;
        bus.memAck    = 1'b0;
        bus.memRData  = 32'h0;
        tick();
        tick();
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_memReq", 32'(bus.memReq), 32'd0);
        chk("rst_memBe", 32'(bus.memBe), 32'd0);
        chk("rst_memAddr", bus.memAddr, 32'd0);
        chk("rst_loadValid", 32'(bus.loadValid), 32'd0);
        chk("rst_loadWord", bus.loadWord, 32'd0);
        chk("rst_rdOut", 32'(bus.rdOut), 32'd0);
        chk("rst_accessErr", 32'(bus.accessErr), 32'd0);
        reset        = 1'b0;
        bus.reqValid = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Misaligned word load: no memory access, one-cycle error.
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b0;
        bus.reqByte  = 1'b0;
        bus.reqAddr  = 32'h0000_0006;
        #1;
        chk("mis_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.reqValid = 1'b0;
        chk("mis_memReq", 32'(bus.memReq), 32'd0);
        chk("mis_accessErr", 32'(bus.accessErr), 32'd1);
        tick();
        chk("mis_err_clear", 32'(bus.accessErr), 32'd0);

        // Timeout: memAck never arrives.
        bus.reqValid = 1'b1;
        bus.reqAddr  = 32'h0000_0010;
        tick();
        bus.reqValid = 1'b0;
        busy = 0;
        while (bus.memReq === 1'b1 && busy < 40) begin
            busy++;
            tick();
        end
        chk("to_memReq_cycles", 32'(busy), 32'd15);
        chk("to_accessErr", 32'(bus.accessErr), 32'd1);
        chk("to_loadValid", 32'(bus.loadValid), 32'd0);
        tick();
        chk("to_err_clear", 32'(bus.accessErr), 32'd0);
        run_txn(vecs[2]);

        // Back-to-back loads with reqValid held through RESP.
        bus.reqValid  = 1'b1;
        bus.reqWrite  = 1'b0;
        bus.reqByte   = 1'b0;
        bus.reqSigned = 1'b0;
        bus.reqAddr   = 32'h0000_0020;
        bus.rdIn      = 5'd3;
        tick();
        bus.reqAddr  = 32'h0000_0024;
        bus.rdIn     = 5'd4;
        bus.memAck   = 1'b1;
        bus.memRData = 32'hAAAA_0001;
        tick();
        bus.memAck = 1'b0;
        #1;
        chk("b2b_loadValid1", 32'(bus.loadValid), 32'd1);
        chk("b2b_loadWord1", bus.loadWord, 32'hAAAA_0001);
        chk("b2b_rdOut1", 32'(bus.rdOut), 32'd3);
        chk("b2b_resp_stall", 32'(bus.stall), 32'd1);
        tick();
        bus.reqValid = 1'b0;
        chk("b2b_memReq2", 32'(bus.memReq), 32'd1);
        chk("b2b_memAddr2", bus.memAddr, 32'h0000_0024);
        chk("b2b_loadValid_busy", 32'(bus.loadValid), 32'd0);
        bus.memAck   = 1'b1;
        bus.memRData = 32'h0000_BBBB;
        tick();
        bus.memAck = 1'b0;
        chk("b2b_loadValid2", 32'(bus.loadValid), 32'd1);
        chk("b2b_loadWord2", bus.loadWord, 32'h0000_BBBB);
        chk("b2b_rdOut2", 32'(bus.rdOut), 32'd4);
        tick();

        // Reset in the second BUSY cycle, followed by a stray memAck.
        bus.reqValid = 1'b1;
        bus.reqAddr  = 32'h0000_0030;
        bus.rdIn     = 5'd9;
        tick();
        bus.reqValid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bus.memAck   = 1'b1;
        bus.memRData = 32'h5555_5555;
        #1;
        chk("rb_memReq", 32'(bus.memReq), 32'd0);
        chk("rb_memAddr", bus.memAddr, 32'd0);
        chk("rb_memBe", 32'(bus.memBe), 32'd0);
        chk("rb_rdOut", 32'(bus.rdOut), 32'd0);
        chk("rb_loadWord", bus.loadWord, 32'd0);
        chk("rb_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.memAck = 1'b0;
        chk("rb_late_loadValid", 32'(bus.loadValid), 32'd0);
        chk("rb_late_accessErr", 32'(bus.accessErr), 32'd0);
        chk("rb_late_memReq", 32'(bus.memReq), 32'd0);
        chk("rb_late_loadWord", bus.loadWord, 32'd0);
        run_txn(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
